// File: rtl/eth_axi_pkg.sv
// eth_axi_pkg: shared types and address decode helper for the eth_axi register file.
package eth_axi_pkg;

    // AXI response codes used by this slave
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_RESP } rd_state_t;

    // Width used for decoded indices so any ADDR_W up to 64 fits
    localparam int IDX_FULL_W = 64;

    // Register index of a byte address: drop the byte-offset bits
    function automatic logic [IDX_FULL_W-1:0] idx_of(input logic [IDX_FULL_W-1:0] addr,
                                                     input int lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/eth_axi_byte_merge.sv
// eth_axi_byte_merge: combinational WSTRB merge of a write word into an old word.
module eth_axi_byte_merge
    import eth_axi_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   merged_o
);

    // Per byte lane: take the write byte where its strobe is set, else keep old
    always_comb begin
        merged_o = old_i;
        for (int k = 0; k < DATA_W/8; k++) begin
            if (wstrb_i[k]) merged_o[8*k +: 8] = wdata_i[8*k +: 8];
        end
    end

endmodule

// File: rtl/eth_axi_regfile.sv
// eth_axi_regfile: parametrised AXI4-Lite slave register file with read-only
// hardware status slots, WSTRB merging and decode-error responses.
// Optional feature macro: ETH_AXI_IRQ_EN turns the top register into a W1C
// interrupt status register and adds the irq_set/irq ports.
module eth_axi_regfile
    import eth_axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_REGS = 8,
    parameter int N_RO   = 2,
    parameter int ADDR_W = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [DATA_W-1:0]        S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]      S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [DATA_W-1:0]        S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    input  logic [N_RO*DATA_W-1:0]   hw_status,
`ifdef ETH_AXI_IRQ_EN
    input  logic [DATA_W-1:0]        irq_set,
    output logic                     irq,
`endif
    output logic [N_REGS*DATA_W-1:0] reg_q
);

    localparam int BPW   = DATA_W / 8;
    localparam int LSB   = $clog2(BPW);
    localparam int IDX_W = $clog2(N_REGS);

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BPW-1:0]    wstrb_q, wstrb_d;
    resp_t             bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [N_REGS-1:0][DATA_W-1:0] regs;
    logic                  aw_hs, w_hs, commit;
    logic [ADDR_W-1:0]     aw_addr_eff;
    logic [DATA_W-1:0]     w_data_eff, merged;
    logic [BPW-1:0]        w_strb_eff;
    logic [IDX_FULL_W-1:0] widx_full, ridx_full;
    logic                  w_ok, r_in_range;
    logic [IDX_W-1:0]      widx, ridx;
    logic                  unused_prot;

    assign unused_prot   = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign S_AXI_AWREADY = !aw_held_q && (wr_state_q == W_IDLE);
    assign S_AXI_WREADY  = !w_held_q  && (wr_state_q == W_IDLE);
    assign S_AXI_BVALID  = (wr_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (rd_state_q == R_IDLE);
    assign S_AXI_RVALID  = (rd_state_q == R_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_q         = regs;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

    // A beat arriving this cycle is used directly so AW+W together commit at once
    assign aw_addr_eff = aw_held_q ? awaddr_q : S_AXI_AWADDR;
    assign w_data_eff  = w_held_q  ? wdata_q  : S_AXI_WDATA;
    assign w_strb_eff  = w_held_q  ? wstrb_q  : S_AXI_WSTRB;
    assign commit      = (wr_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign widx_full  = idx_of(IDX_FULL_W'(aw_addr_eff), LSB);
    assign w_ok       = (widx_full < IDX_FULL_W'(N_REGS)) && (widx_full >= IDX_FULL_W'(N_RO));
    assign widx       = widx_full[IDX_W-1:0];
    assign ridx_full  = idx_of(IDX_FULL_W'(S_AXI_ARADDR), LSB);
    assign r_in_range = ridx_full < IDX_FULL_W'(N_REGS);
    assign ridx       = ridx_full[IDX_W-1:0];

    eth_axi_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_i    (regs[widx]),
        .wdata_i  (w_data_eff),
        .wstrb_i  (w_strb_eff),
        .merged_o (merged)
    );

    // Read-only slots mirror the live hardware status
    for (genvar i = 0; i < N_RO; i++) begin : g_ro
        assign regs[i] = hw_status[i*DATA_W +: DATA_W];
    end

`ifdef ETH_AXI_IRQ_EN
    logic [DATA_W-1:0] clr_mask;
    logic              irq_q;

    // Bits to clear: write data restricted to strobed bytes
    eth_axi_byte_merge #(.DATA_W(DATA_W)) u_clr (
        .old_i    ('0),
        .wdata_i  (w_data_eff),
        .wstrb_i  (w_strb_eff),
        .merged_o (clr_mask)
    );

    // Interrupt line follows the OR of the status register
    always_ff @(posedge ACLK) begin
        if (ARESET) irq_q <= 1'b0;
        else        irq_q <= |regs[N_REGS-1];
    end
    assign irq = irq_q;
`endif

    for (genvar i = N_RO; i < N_REGS; i++) begin : g_rw
        logic              wr_en;
        logic [DATA_W-1:0] q;
        assign wr_en = commit && w_ok && (widx == IDX_W'(i));
`ifdef ETH_AXI_IRQ_EN
        if (i == N_REGS - 1) begin : g_w1c
            // W1C status: a set pulse wins over a clear of the same bit
            always_ff @(posedge ACLK) begin
                if (ARESET) q <= '0;
                else        q <= (q & ~(wr_en ? clr_mask : '0)) | irq_set;
            end
        end else begin : g_plain
            // Plain RW register, byte-merged on commit
            always_ff @(posedge ACLK) begin
                if (ARESET)     q <= '0;
                else if (wr_en) q <= merged;
            end
        end
`else
        // Plain RW register, byte-merged on commit
        always_ff @(posedge ACLK) begin
            if (ARESET)     q <= '0;
            else if (wr_en) q <= merged;
        end
`endif
        assign regs[i] = q;
    end

    // Channel FSM state, held AW/W beats and registered responses
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    // Write channel: capture AW and W independently, commit once both are present
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                end
                if (commit) begin
                    wr_state_d = W_RESP;
                    bresp_d    = w_ok ? OKAY : SLVERR;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = W_IDLE;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read channel: sample register view at accept, hold until RREADY
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rd_state_d = R_RESP;
                    rdata_d    = r_in_range ? regs[ridx] : '0;
                    rresp_d    = r_in_range ? OKAY : SLVERR;
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_axi_regfile.sv
// tb_eth_axi_regfile: table vectors, hand sequences and randomized traffic
// against a behavioural register-map model. Honours ETH_AXI_IRQ_EN.
module tb_eth_axi_regfile;

    localparam int DATA_W = 32;
    localparam int N_REGS = 8;
    localparam int N_RO   = 2;
    localparam int ADDR_W = 8;
    localparam logic [1:0] OK_R  = 2'b00;
    localparam logic [1:0] ERR_R = 2'b10;
`ifdef ETH_AXI_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic                     aclk = 1'b0;
    logic                     areset = 1'b1;
    logic [ADDR_W-1:0]        awaddr = '0, araddr = '0;
    logic [2:0]               awprot = '0, arprot = '0;
    logic                     awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic                     arvalid = 1'b0, rready = 1'b0;
    logic [DATA_W-1:0]        wdata = '0;
    logic [3:0]               wstrb = '0;
    logic                     awready, wready, bvalid, arready, rvalid;
    logic [1:0]               bresp, rresp;
    logic [DATA_W-1:0]        rdata;
    logic [N_RO*DATA_W-1:0]   hw_status = {32'h0000BEEF, 32'h5A5A0001};
    logic [N_REGS*DATA_W-1:0] reg_q;
`ifdef ETH_AXI_IRQ_EN
    logic [DATA_W-1:0]        irq_set = '0;
    logic                     irq;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [N_REGS];

    always #5 aclk = ~aclk;

    eth_axi_regfile #(.DATA_W(DATA_W), .N_REGS(N_REGS), .N_RO(N_RO), .ADDR_W(ADDR_W)) dut (
        .ACLK(aclk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .hw_status(hw_status),
`ifdef ETH_AXI_IRQ_EN
        .irq_set(irq_set), .irq(irq),
`endif
        .reg_q(reg_q)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Register map model: byte offset / 4 selects a register
    function automatic logic [31:0] slot_exp(input int i);
        return (i < N_RO) ? hw_status[i*32 +: 32] : mdl[i];
    endfunction

    function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx = int'(a) / 4;
        if (idx >= N_REGS || idx < N_RO) return ERR_R;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) begin
                if (IRQ_BUILD && idx == N_REGS - 1) mdl[idx][8*k +: 8] &= ~d[8*k +: 8];
                else                                 mdl[idx][8*k +: 8] = d[8*k +: 8];
            end
        end
        return OK_R;
    endfunction

    task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx = int'(a) / 4;
        if (idx >= N_REGS) begin d = '0; r = ERR_R; end
        else begin d = slot_exp(idx); r = OK_R; end
    endtask

    task automatic check_regq(input string name);
        int bad = -1;
        for (int i = 0; i < N_REGS; i++)
            if (reg_q[i*32 +: 32] !== slot_exp(i)) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: slot %0d got %h, expected %h", name, bad, reg_q[bad*32 +: 32], slot_exp(bad));
        end
    endtask

    // lead > 0: W issued lead cycles before AW; lead < 0: AW first; bhold: cycles BREADY held low
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int bhold, output logic [1:0] resp);
        bit aw_done, w_done, aw_go, w_go, stable;
        int c;
        logic [1:0] r0;
        aw_done = 0; w_done = 0; c = 0; resp = 2'b11;
        while (!(aw_done && w_done) && c < 50) begin
            @(negedge aclk);
            awvalid = !aw_done && (c >= (lead > 0 ? lead : 0));
            wvalid  = !w_done  && (c >= (lead < 0 ? -lead : 0));
            awaddr = addr; wdata = data; wstrb = strb;
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge aclk);
            if (aw_go) aw_done = 1;
            if (w_go)  w_done = 1;
            c++;
        end
        @(negedge aclk);
        awvalid = 0; wvalid = 0;
        chk("wr_handshake", {63'd0, aw_done && w_done}, 64'd1);
        if (!(aw_done && w_done)) return;
        chk("b_latency", {63'd0, bvalid}, 64'd1);
        c = 0;
        while (!bvalid && c < 20) begin @(negedge aclk); c++; end
        if (!bvalid) return;
        r0 = bresp; stable = 1;
        for (int i = 0; i < bhold; i++) begin
            @(negedge aclk);
            if (!bvalid || bresp !== r0 || awready || wready) stable = 0;
        end
        if (bhold > 0) chk("b_hold_stable", {63'd0, stable}, 64'd1);
        bready = 1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 0;
        chk("b_drop", {63'd0, bvalid}, 64'd0);
        resp = r0;
    endtask

    task automatic do_read(input logic [7:0] addr, input int rhold,
                           output logic [31:0] data, output logic [1:0] resp);
        bit go, stable;
        int c;
        go = 0; c = 0; data = '0; resp = 2'b11;
        while (!go && c < 50) begin
            @(negedge aclk);
            arvalid = 1; araddr = addr;
            go = arready;
            @(posedge aclk);
            c++;
        end
        @(negedge aclk);
        arvalid = 0;
        chk("ar_handshake", {63'd0, go}, 64'd1);
        if (!go) return;
        chk("r_latency", {63'd0, rvalid}, 64'd1);
        data = rdata; resp = rresp; stable = 1;
        for (int i = 0; i < rhold; i++) begin
            @(negedge aclk);
            if (!rvalid || rdata !== data || rresp !== resp || arready) stable = 0;
        end
        if (rhold > 0) chk("r_hold_stable", {63'd0, stable}, 64'd1);
        rready = 1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 0;
        chk("r_drop", {63'd0, rvalid}, 64'd0);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        int          bhold;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [1:0]  br, rr, eb, er;
        logic [31:0] rd, ed, d;
        logic [7:0]  a;
        logic [3:0]  s;
        int          lead, bh;

        vecs[0] = '{8'h08, 32'hDEADBEEF, 4'hF, 0,  0, OK_R,  32'hDEADBEEF, OK_R};
        vecs[1] = '{8'h0C, 32'h11223344, 4'hF, -2, 5, OK_R,  32'h11223344, OK_R};
        vecs[2] = '{8'h0C, 32'hAABBCCDD, 4'h2, 3,  0, OK_R,  32'h1122CC44, OK_R};
        vecs[3] = '{8'h00, 32'hFFFFFFFF, 4'hF, 0,  0, ERR_R, 32'h5A5A0001, OK_R};
        vecs[4] = '{8'h40, 32'h12345678, 4'hF, 0,  0, ERR_R, 32'h00000000, ERR_R};
        vecs[5] = '{8'h1E, 32'h01020304, 4'h9, 1,  0, OK_R,
                    IRQ_BUILD ? 32'h00000000 : 32'h01000004, OK_R};
        vecs[6] = '{8'h04, 32'h00000000, 4'hF, -1, 0, ERR_R, 32'h0000BEEF, OK_R};
        vecs[7] = '{8'hFC, 32'h00000001, 4'hF, 0,  0, ERR_R, 32'h00000000, ERR_R};
        vecs[8] = '{8'h10, 32'hCAFEF00D, 4'h0, 0,  0, OK_R,  32'h00000000, OK_R};
        vecs[9] = '{8'h08, 32'h00000000, 4'hC, 2,  0, OK_R,  32'h0000BEEF, OK_R};
        for (int i = 0; i < N_REGS; i++) mdl[i] = '0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 0;
        @(negedge aclk);
        chk("rst_awready", {63'd0, awready}, 64'd1);
        chk("rst_wready",  {63'd0, wready},  64'd1);
        chk("rst_arready", {63'd0, arready}, 64'd1);
        chk("rst_bvalid",  {63'd0, bvalid},  64'd0);
        chk("rst_rvalid",  {63'd0, rvalid},  64'd0);
        chk("rst_rdata",   {32'd0, rdata},   64'd0);
        check_regq("rst_regq");

        // Table vectors: write, then read back the same address
        for (int i = 0; i < 10; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, vecs[i].bhold, br);
            eb = model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            chk($sformatf("vec%0d_bresp", i), {62'd0, br}, {62'd0, vecs[i].exp_bresp});
            do_read(vecs[i].addr, (i == 3) ? 2 : 0, rd, rr);
            chk($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].exp_rdata});
            chk($sformatf("vec%0d_rresp", i), {62'd0, rr}, {62'd0, vecs[i].exp_rresp});
            check_regq($sformatf("vec%0d_regq", i));
        end

        // Read accepted on the same edge as a write commit returns the pre-write value
        @(negedge aclk);
        chk("rw_idle_ready", {61'd0, awready, wready, arready}, 64'd7);
        awvalid = 1; wvalid = 1; arvalid = 1;
        awaddr = 8'h0C; araddr = 8'h0C; wdata = 32'h0BADF00D; wstrb = 4'hF;
        ed = mdl[3];
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        eb = model_write(8'h0C, 32'h0BADF00D, 4'hF);
        chk("rw_rvalid", {63'd0, rvalid}, 64'd1);
        chk("rw_bvalid", {63'd0, bvalid}, 64'd1);
        chk("rw_old_data", {32'd0, rdata}, {32'd0, ed});
        check_regq("rw_regq");
        bready = 1; rready = 1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 0; rready = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            lead = int'($urandom_range(0, 6)) - 3;
            bh = int'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) hw_status = {$urandom, $urandom};
            do_write(a, d, s, lead, bh, br);
            eb = model_write(a, d, s);
            chk("rnd_bresp", {62'd0, br}, {62'd0, eb});
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            model_read(a, ed, er);
            do_read(a, int'($urandom_range(0, 1)), rd, rr);
            chk("rnd_rdata", {32'd0, rd}, {32'd0, ed});
            chk("rnd_rresp", {62'd0, rr}, {62'd0, er});
            check_regq("rnd_regq");
        end

`ifdef ETH_AXI_IRQ_EN
        // Interrupt status: set pulse, W1C clear, set wins over clear
        @(negedge aclk);
        irq_set = 32'h5;
        @(negedge aclk);
        irq_set = '0;
        mdl[N_REGS-1] = mdl[N_REGS-1] | 32'h5;
        @(negedge aclk);
        chk("irq_asserted", {63'd0, irq}, 64'd1);
        check_regq("irq_set_regq");
        do_write(8'h1C, 32'h1, 4'hF, 0, 0, br);
        eb = model_write(8'h1C, 32'h1, 4'hF);
        chk("irq_w1c_bresp", {62'd0, br}, {62'd0, OK_R});
        check_regq("irq_w1c_regq");
        @(negedge aclk);
        awvalid = 1; wvalid = 1; awaddr = 8'h1C; wdata = 32'h4; wstrb = 4'hF; irq_set = 32'h4;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 0; wvalid = 0; irq_set = '0;
        mdl[N_REGS-1] = (mdl[N_REGS-1] & ~32'h4) | 32'h4;
        chk("irq_setwin_bvalid", {63'd0, bvalid}, 64'd1);
        check_regq("irq_setwin_regq");
        bready = 1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 0;
`endif

        // Reset with an AW beat held: everything dropped, a lone W must not commit
        @(negedge aclk);
        awvalid = 1; awaddr = 8'h10;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 0; areset = 1;
        @(posedge aclk);
        @(negedge aclk);
        areset = 0;
        for (int i = 0; i < N_REGS; i++) mdl[i] = '0;
        chk("midrst_awready", {63'd0, awready}, 64'd1);
        chk("midrst_wready",  {63'd0, wready},  64'd1);
        chk("midrst_bvalid",  {63'd0, bvalid},  64'd0);
        check_regq("midrst_regq");
        wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        @(posedge aclk);
        @(negedge aclk);
        wvalid = 0;
        repeat (2) @(negedge aclk);
        chk("midrst_no_commit", {63'd0, bvalid}, 64'd0);
        check_regq("midrst_no_commit_regq");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
